// File: rtl/load_store_unit.sv
// load_store_unit: single-port RV32I load/store unit in front of a word-wide
// data memory with combinational read and rising-edge write.
// Sub-word loads select and extend a lane; sub-word stores use a
// read-modify-write so that only the addressed bytes of the word change.
// Optional feature macro: LSU_ERR_EN. When defined, misaligned halfword or word
// accesses and illegal funct3 codes complete with err=1 and no memory access.
// When it is undefined, err is tied 0, misaligned addresses are truncated to
// the natural alignment of the size, and illegal funct3 codes act as W.
//
// Handshake: a request is taken on a rising edge where req_valid and
// req_ready are both 1; req_ready is 1 only in IDLE. resp_valid is a one-cycle
// pulse with rdata/err valid alongside it. The core cannot stall a response.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  input  logic [31:0] mem_RD
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t      state;
  size_t       sz_r;
  logic [1:0]  off_r;
  logic        sign_r;
  logic [31:0] wdata_r;
  logic [31:0] wd_r;
  logic        we_q;

  size_t       in_sz;
  logic [1:0]  in_off;
  logic        in_bad;
  logic [7:0]  lane8;
  logic [15:0] lane16;
  logic [31:0] load_val;
  logic [31:0] merged;

  // Decode size, effective lane offset and error status of the incoming request
  always_comb begin
    if (req_we) begin
      case (funct3)
        3'b000:  in_sz = SZ_B;
        3'b001:  in_sz = SZ_H;
        default: in_sz = SZ_W;
      endcase
    end else begin
      case (funct3[1:0])
        2'b00:   in_sz = SZ_B;
        2'b01:   in_sz = SZ_H;
        default: in_sz = SZ_W;
      endcase
    end
    case (in_sz)
      SZ_B:    in_off = addr[1:0];
      SZ_H:    in_off = {addr[1], 1'b0};
      default: in_off = 2'b00;
    endcase
`ifdef LSU_ERR_EN
    in_bad = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (req_we && funct3[2]) ||
             ((in_sz == SZ_H) && addr[0]) || ((in_sz == SZ_W) && (addr[1:0] != 2'b00));
`else
    in_bad = 1'b0;
`endif
  end

  // Lane extraction for loads and lane merge for sub-word stores
  always_comb begin
    lane8    = mem_RD[{off_r, 3'b000} +: 8];
    lane16   = mem_RD[{off_r[1], 4'b0000} +: 16];
    load_val = mem_RD;
    merged   = mem_RD;
    case (sz_r)
      SZ_B: begin
        load_val = {{24{sign_r & lane8[7]}}, lane8};
        merged[{off_r, 3'b000} +: 8] = wdata_r[7:0];
      end
      SZ_H: begin
        load_val = {{16{sign_r & lane16[15]}}, lane16};
        merged[{off_r[1], 4'b0000} +: 16] = wdata_r[15:0];
      end
      default: ;
    endcase
  end

`ifdef LSU_ERR_EN
  logic err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // A reset in the WRITE cycle must not reach the memory
  assign mem_WE = we_q & ~rst;
  assign mem_WD = wd_r;

  // Control FSM with registered handshake and memory-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      we_q       <= 1'b0;
      rdata      <= 32'h0;
      mem_A      <= 32'h0;
      sz_r       <= SZ_W;
      off_r      <= 2'b00;
      sign_r     <= 1'b0;
      wdata_r    <= 32'h0;
      wd_r       <= 32'h0;
`ifdef LSU_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            mem_A     <= {addr[31:2], 2'b00};
            sz_r      <= in_sz;
            off_r     <= in_off;
            sign_r    <= ~funct3[2];
            wdata_r   <= wdata;
            wd_r      <= wdata;
`ifdef LSU_ERR_EN
            err_q     <= in_bad;
`endif
            if (in_bad) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else if (!req_we) begin
              state <= LOAD;
            end else if (in_sz == SZ_W) begin
              state <= WRITE;
              we_q  <= 1'b1;
            end else begin
              state <= RMW_RD;
            end
          end
        end
        LOAD: begin
          rdata      <= load_val;
          state      <= RESP;
          resp_valid <= 1'b1;
        end
        RMW_RD: begin
          wd_r  <= merged;
          state <= WRITE;
          we_q  <= 1'b1;
        end
        WRITE: begin
          we_q       <= 1'b0;
          state      <= RESP;
          resp_valid <= 1'b1;
        end
        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          mem_A      <= 32'h0;
          state      <= IDLE;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have no parameters; address and data widths are fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  core presents a memory request.
REQ-005 req_ready  output  1  unit idle and accepting a request.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 funct3  input  3  RV32I size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 addr  input  32  byte address.
REQ-009 wdata  input  32  store data; low byte or low half used for sub-word stores.
REQ-010 resp_valid  output  1  one-cycle pulse: request complete.
REQ-011 rdata  output  32  extended load result, valid with resp_valid.
REQ-012 err  output  1  misaligned or illegal request, valid with resp_valid.
REQ-013 mem_A  output  32  word-aligned address to data memory (addr[1:0] forced 00).
REQ-014 mem_WD  output  32  full word written to data memory.
REQ-015 mem_WE  output  1  data memory write enable; memory writes on the clk rising edge.
REQ-016 mem_RD  input  32  combinational read data from data memory at mem_A.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, RMW_RD, WRITE and RESP; req_ready=1 only in IDLE.
REQ-018 Accepting a request (req_valid & req_ready at edge N) SHALL latch req_we, funct3, addr and wdata; req_valid in any other state SHALL be ignored.
REQ-019 From IDLE, transitions: load->LOAD; SW->WRITE; SB/SH->RMW_RD; error->RESP with no memory access.
REQ-020 In LOAD, at edge N+1 rdata SHALL capture the selected lane of mem_RD, sign-extended for B/H and zero-extended for BU/HU; state->RESP.
REQ-021 Byte lane SHALL be addr[1:0] (little-endian); half lane SHALL be addr[1] (bits 15:0 or 31:16).
REQ-022 In RMW_RD, at edge N+1 the unit SHALL capture mem_RD and merge wdata into the addressed lane(s), leaving other bytes unchanged; state->WRITE.
REQ-023 In WRITE, mem_WE=1 and mem_WD = merged word (SB/SH) or wdata (SW) for exactly one cycle; state->RESP.
REQ-024 In RESP, resp_valid=1 for exactly one cycle; state->IDLE.
REQ-025 Latency from acceptance edge to resp_valid: load 1 cycle, SW 1 cycle, SB/SH 2 cycles, error 0 cycles (resp_valid high in the cycle after the acceptance edge, i.e. RESP entered at N, N+1 or N+2).
REQ-026 mem_WE SHALL be 0 in every state except WRITE; mem_A SHALL hold the latched aligned address outside IDLE, and 0 in IDLE.
REQ-027 rdata SHALL hold its value until the next load completes; stores SHALL leave rdata unchanged.
REQ-028 Store to address with lane overlapping another byte: only addressed bytes SHALL change; mem_RD is sampled in RMW_RD only.

Reset
REQ-029 While rst=1 at an edge, state SHALL become IDLE; rdata, err, resp_valid = 0; req_ready=1 after that edge.
REQ-030 mem_WE SHALL be forced 0 combinationally in any cycle rst=1, so a WRITE interrupted by reset performs no write.
REQ-031 A request pending when reset is asserted SHALL be discarded with no response.

Configuration
REQ-032 Macro LSU_ERR_EN: when defined, H with addr[0]=1, W with addr[1:0]!=00, and funct3 in {011,110,111} (or 100/101 on store) SHALL set err=1 with no memory access.
REQ-033 Without LSU_ERR_EN, err SHALL be tied 0, misaligned addresses SHALL be truncated to the natural alignment of the size, and illegal funct3 SHALL be treated as W.

Verification
REQ-034 Mem word 0x10 = 0x8070F0A5; LB addr 0x11 -> rdata 0xFFFFFFF0; LBU addr 0x11 -> 0x000000F0; resp_valid 1 cycle after acceptance.
REQ-035 Same word; LH addr 0x12 -> 0xFFFF8070; LW addr 0x10 -> 0x8070F0A5.
REQ-036 SB wdata 0x123456CC addr 0x13 -> one mem_WE pulse, word becomes 0xCC70F0A5; resp_valid 2 cycles after acceptance.
REQ-037 SH wdata 0xDEADBEEF addr 0x10 then LW 0x10 -> 0x8070BEEF.
REQ-038 With LSU_ERR_EN: LW addr 0x12 -> err=1, resp_valid next cycle, mem_WE never asserted; without it: reads word 0x10.
REQ-039 Assert rst in the WRITE cycle of an SB -> no write, no resp_valid, req_ready=1 after the edge.
